// File: rtl/axi_led_pkg.sv
// Shared definitions for the AXI4-Lite LED slave.
// Contents: register index encoding (ADDR[3:2]), CTRL bit positions, AXI response
// codes, handshake FSM state types, and a byte-strobe merge helper.
package axi_led_pkg;

    // Register index as decoded from ADDR[3:2] (byte offsets 0x0/0x4/0x8/0xC).
    typedef enum logic [1:0] {
        RegCtrl   = 2'd0,
        RegLedPat = 2'd1,
        RegPeriod = 2'd2,
        RegStatus = 2'd3
    } reg_idx_e;

    localparam int unsigned CTRL_EN_BIT    = 0;
    localparam int unsigned CTRL_BLINK_BIT = 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Write channel: AW and W buffers fill independently, then commit, then respond.
    typedef enum logic [2:0] {
        StWrIdle,
        StWrAddr,
        StWrData,
        StWrBoth,
        StWrResp
    } wr_state_e;

    typedef enum logic {
        StRdIdle,
        StRdResp
    } rd_state_e;

    // Replace only the bytes of old_val whose strobe bit is set.
    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                                input logic [31:0] data,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) begin
                res[8*i +: 8] = data[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/axi_lite_led_slave_if.sv
// AXI4-Lite bus bundle between the LED IP's master and the LED slave.
// Signals: AW (valid/addr/ready), W (valid/data/strb/ready), B (valid/resp/ready),
// AR (valid/addr/ready), R (valid/data/resp/ready).
// Modports: slave (used by axi_lite_led_slave), master (used by the initiator).
interface axi_lite_led_slave_if #(
    parameter int unsigned ADDR_W = 4
);
    logic              S_AWVALID;
    logic [ADDR_W-1:0] S_AWADDR;
    logic              S_AWREADY;
    logic              S_WVALID;
    logic [31:0]       S_WDATA;
    logic [3:0]        S_WSTRB;
    logic              S_WREADY;
    logic              S_BVALID;
    logic [1:0]        S_BRESP;
    logic              S_BREADY;
    logic              S_ARVALID;
    logic [ADDR_W-1:0] S_ARADDR;
    logic              S_ARREADY;
    logic              S_RVALID;
    logic [31:0]       S_RDATA;
    logic [1:0]        S_RRESP;
    logic              S_RREADY;

    modport slave (
        input  S_AWVALID, S_AWADDR, S_WVALID, S_WDATA, S_WSTRB, S_BREADY,
               S_ARVALID, S_ARADDR, S_RREADY,
        output S_AWREADY, S_WREADY, S_BVALID, S_BRESP, S_ARREADY, S_RVALID,
               S_RDATA, S_RRESP
    );

    modport master (
        output S_AWVALID, S_AWADDR, S_WVALID, S_WDATA, S_WSTRB, S_BREADY,
               S_ARVALID, S_ARADDR, S_RREADY,
        input  S_AWREADY, S_WREADY, S_BVALID, S_BRESP, S_ARREADY, S_RVALID,
               S_RDATA, S_RRESP
    );
endinterface

// File: rtl/led_blink_gen.sv
// LED driver: steady or blinking output derived from CTRL/LED_PAT/PERIOD.
// Ports: clk_i, rst_ni (synchronous, active low), en_i, blink_i, period_i (half-period
// in cycles), led_pat_i, restart_i (clears counter/phase) -> led_o (registered), phase_o.
module led_blink_gen #(
    parameter int unsigned LED_W    = 8,
    parameter int unsigned PERIOD_W = 32
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                en_i,
    input  logic                blink_i,
    input  logic [PERIOD_W-1:0] period_i,
    input  logic [LED_W-1:0]    led_pat_i,
    input  logic                restart_i,
    output logic [LED_W-1:0]    led_o,
    output logic                phase_o
);
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic                phase_q, phase_d;
    logic [LED_W-1:0]    led_q, led_d;
    logic                blinking;

    // PERIOD == 0 degenerates to steady on.
    assign blinking = en_i && blink_i && (period_i != '0);

    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        led_d   = '0;
        if (restart_i || !blinking) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (cnt_q >= period_i - PERIOD_W'(1)) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end else begin
            cnt_d = cnt_q + PERIOD_W'(1);
        end
        // Phase 0 is the lit half, so a fresh blink starts lit.
        if (en_i && !(blinking && phase_q)) begin
            led_d = led_pat_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
            led_q   <= '0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            led_q   <= led_d;
        end
    end

    assign led_o   = led_q;
    assign phase_o = phase_q;
endmodule

// File: rtl/axi_lite_led_slave.sv
// AXI4-Lite slave terminating the LED IP's master: CTRL/LED_PAT/PERIOD/STATUS registers
// plus the LED driver.
// Ports: S_ACLK, S_ARESET_N (synchronous, active low), s_axi (slave modport of the
// AXI4-Lite bundle), led_out (LED drive).
module axi_lite_led_slave
    import axi_led_pkg::*;
#(
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned LED_W    = 8,
    parameter int unsigned PERIOD_W = 32
) (
    input  logic                 S_ACLK,
    input  logic                 S_ARESET_N,
    axi_lite_led_slave_if.slave  s_axi,
    output logic [LED_W-1:0]     led_out
);
    wr_state_e         wr_state_q, wr_state_d;
    rd_state_e         rd_state_q, rd_state_d;
    reg_idx_e          aw_idx_q;
    logic [31:0]       wdata_q;
    logic [3:0]        wstrb_q;
    logic [1:0]        bresp_q;
    logic [31:0]       rdata_q;
    logic [1:0]        ctrl_q;
    logic [31:0]       led_pat_q;
    logic [31:0]       period_q;
    logic [ADDR_W-1:0] awaddr, araddr;
    logic              aw_hs, w_hs, ar_hs, commit, restart;
    logic              phase;
    logic [LED_W-1:0]  led;
    logic [31:0]       reg_view [4];
    logic [31:0]       wr_merged;
    logic              unused_addr_lsbs;

    assign awaddr           = s_axi.S_AWADDR;
    assign araddr           = s_axi.S_ARADDR;
    assign unused_addr_lsbs = ^{awaddr[1:0], araddr[1:0]};

    // Readies are held low during reset so every output reads 0 while reset is asserted.
    assign s_axi.S_AWREADY = S_ARESET_N && (wr_state_q inside {StWrIdle, StWrData});
    assign s_axi.S_WREADY  = S_ARESET_N && (wr_state_q inside {StWrIdle, StWrAddr});
    assign s_axi.S_BVALID  = (wr_state_q == StWrResp);
    assign s_axi.S_BRESP   = bresp_q;
    assign s_axi.S_ARREADY = S_ARESET_N && (rd_state_q == StRdIdle);
    assign s_axi.S_RVALID  = (rd_state_q == StRdResp);
    assign s_axi.S_RDATA   = rdata_q;
    assign s_axi.S_RRESP   = RESP_OKAY;

    assign aw_hs   = s_axi.S_AWVALID && s_axi.S_AWREADY;
    assign w_hs    = s_axi.S_WVALID && s_axi.S_WREADY;
    assign ar_hs   = s_axi.S_ARVALID && s_axi.S_ARREADY;
    assign commit  = (wr_state_q == StWrBoth);
    assign restart = commit && (aw_idx_q == RegCtrl || aw_idx_q == RegPeriod);

    always_comb begin
        reg_view[RegCtrl]   = {30'b0, ctrl_q};
        reg_view[RegLedPat] = led_pat_q;
        reg_view[RegPeriod] = period_q;
        reg_view[RegStatus] = {phase, {(31 - LED_W){1'b0}}, led};
    end

    assign wr_merged = apply_wstrb(reg_view[aw_idx_q], wdata_q, wstrb_q);

    always_comb begin
        wr_state_d = wr_state_q;
        case (wr_state_q)
            StWrIdle: begin
                if (aw_hs && w_hs) wr_state_d = StWrBoth;
                else if (aw_hs)    wr_state_d = StWrAddr;
                else if (w_hs)     wr_state_d = StWrData;
            end
            StWrAddr: if (w_hs)  wr_state_d = StWrBoth;
            StWrData: if (aw_hs) wr_state_d = StWrBoth;
            StWrBoth: wr_state_d = StWrResp;
            StWrResp: if (s_axi.S_BREADY) wr_state_d = StWrIdle;
            default:  wr_state_d = StWrIdle;
        endcase
    end

    always_comb begin
        rd_state_d = rd_state_q;
        case (rd_state_q)
            StRdIdle: if (ar_hs) rd_state_d = StRdResp;
            StRdResp: if (s_axi.S_RREADY) rd_state_d = StRdIdle;
            default:  rd_state_d = StRdIdle;
        endcase
    end

    always_ff @(posedge S_ACLK) begin
        if (!S_ARESET_N) begin
            wr_state_q <= StWrIdle;
            rd_state_q <= StRdIdle;
            aw_idx_q   <= RegCtrl;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bresp_q    <= RESP_OKAY;
            rdata_q    <= '0;
            ctrl_q     <= '0;
            led_pat_q  <= '0;
            period_q   <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
            if (aw_hs) aw_idx_q <= reg_idx_e'(awaddr[3:2]);
            if (w_hs) begin
                wdata_q <= s_axi.S_WDATA;
                wstrb_q <= s_axi.S_WSTRB;
            end
            if (commit) begin
                bresp_q <= RESP_OKAY;
                case (aw_idx_q)
                    RegCtrl:   ctrl_q    <= wr_merged[1:0];
                    RegLedPat: led_pat_q <= wr_merged;
                    RegPeriod: period_q  <= wr_merged;
                    default:   bresp_q   <= RESP_SLVERR;
                endcase
            end
            // Sampled from pre-commit register values, so a same-edge write is not visible.
            if (ar_hs) rdata_q <= reg_view[araddr[3:2]];
        end
    end

    led_blink_gen #(
        .LED_W    (LED_W),
        .PERIOD_W (PERIOD_W)
    ) u_blink (
        .clk_i     (S_ACLK),
        .rst_ni    (S_ARESET_N),
        .en_i      (ctrl_q[CTRL_EN_BIT]),
        .blink_i   (ctrl_q[CTRL_BLINK_BIT]),
        .period_i  (period_q[PERIOD_W-1:0]),
        .led_pat_i (led_pat_q[LED_W-1:0]),
        .restart_i (restart),
        .led_o     (led),
        .phase_o   (phase)
    );

    assign led_out = led;
endmodule

// File: tb/tb_axi_lite_led_slave.sv
// Self-checking bench for axi_lite_led_slave: reset, table of write/read vectors,
// hand sequences for B/R stalls, blink timing and reset mid-read, then random
// traffic against a register-level reference model.
module tb_axi_lite_led_slave;
    localparam int unsigned LED_W = 8;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic clk = 1'b0;
    logic rst_n;
    logic [LED_W-1:0] led_out;

    always #5 clk = ~clk;

    axi_lite_led_slave_if #(.ADDR_W(4)) bus ();

    axi_lite_led_slave #(
        .ADDR_W   (4),
        .LED_W    (LED_W),
        .PERIOD_W (32)
    ) dut (
        .S_ACLK     (clk),
        .S_ARESET_N (rst_n),
        .s_axi      (bus),
        .led_out    (led_out)
    );

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        logic [3:0]  waddr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [1:0]  exp_resp;
        logic [3:0]  raddr;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [9];
    logic [31:0] m_regs [3];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_vec++;
        n_miss++;
        $display("FAIL %s: handshake timed out", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old_val, input logic [31:0] data,
                                          input logic [3:0] strb);
        logic [31:0] m;
        m = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
        return (old_val & ~m) | (data & m);
    endfunction

    task automatic drive_aw(input logic [3:0] addr, input int dly);
        logic hs;
        hs = 1'b0;
        repeat (dly) tick();
        bus.S_AWVALID = 1'b1;
        bus.S_AWADDR  = addr;
        for (int k = 0; k < 40; k++) begin
            hs = bus.S_AWREADY;
            tick();
            if (hs) break;
        end
        bus.S_AWVALID = 1'b0;
        if (!hs) timeout("aw_ready");
    endtask

    task automatic drive_w(input logic [31:0] data, input logic [3:0] strb, input int dly);
        logic hs;
        hs = 1'b0;
        repeat (dly) tick();
        bus.S_WVALID = 1'b1;
        bus.S_WDATA  = data;
        bus.S_WSTRB  = strb;
        for (int k = 0; k < 40; k++) begin
            hs = bus.S_WREADY;
            tick();
            if (hs) break;
        end
        bus.S_WVALID = 1'b0;
        if (!hs) timeout("w_ready");
    endtask

    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int awd, input int wd,
                             output logic [1:0] resp);
        logic got;
        got  = 1'b0;
        resp = 2'b11;
        fork
            drive_aw(addr, awd);
            drive_w(data, strb, wd);
        join
        bus.S_BREADY = 1'b1;
        for (int k = 0; k < 40; k++) begin
            if (bus.S_BVALID) begin
                resp = bus.S_BRESP;
                got  = 1'b1;
            end
            tick();
            if (got) break;
        end
        bus.S_BREADY = 1'b0;
        if (!got) timeout("bvalid");
    endtask

    task automatic axi_read(input logic [3:0] addr, output logic [31:0] data);
        logic hs;
        logic got;
        hs   = 1'b0;
        got  = 1'b0;
        data = 32'hDEAD_BEEF;
        bus.S_ARVALID = 1'b1;
        bus.S_ARADDR  = addr;
        for (int k = 0; k < 40; k++) begin
            hs = bus.S_ARREADY;
            tick();
            if (hs) break;
        end
        bus.S_ARVALID = 1'b0;
        if (!hs) timeout("ar_ready");
        bus.S_RREADY = 1'b1;
        for (int k = 0; k < 40; k++) begin
            if (bus.S_RVALID) begin
                data = bus.S_RDATA;
                got  = 1'b1;
            end
            tick();
            if (got) break;
        end
        bus.S_RREADY = 1'b0;
        if (!got) timeout("rvalid");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  resp;
        logic [31:0] rd;
        logic [1:0]  idx;
        logic [1:0]  lo;
        logic [31:0] data;
        logic [3:0]  strb;
        logic        hs;

        vecs[0] = '{4'h4, 32'h1122_3344, 4'hF, OKAY,   4'h4, 32'h1122_3344};
        vecs[1] = '{4'h4, 32'hAABB_CCDD, 4'h5, OKAY,   4'h4, 32'h11BB_33DD};
        vecs[2] = '{4'h0, 32'hFFFF_FFFF, 4'hF, OKAY,   4'h0, 32'h0000_0003};
        vecs[3] = '{4'h0, 32'h0000_0000, 4'h0, OKAY,   4'h0, 32'h0000_0003};
        vecs[4] = '{4'h8, 32'h1234_5678, 4'h3, OKAY,   4'h8, 32'h0000_5678};
        vecs[5] = '{4'h0, 32'h0000_0000, 4'hF, OKAY,   4'h0, 32'h0000_0000};
        vecs[6] = '{4'hC, 32'h0000_00FF, 4'hF, SLVERR, 4'hC, 32'h0000_0000};
        vecs[7] = '{4'h5, 32'hCAFE_0000, 4'hC, OKAY,   4'h6, 32'hCAFE_33DD};
        vecs[8] = '{4'hB, 32'h0000_0000, 4'hF, OKAY,   4'hA, 32'h0000_0000};

        bus.S_AWVALID = 1'b0; bus.S_AWADDR = '0; bus.S_WVALID = 1'b0; bus.S_WDATA = '0;
        bus.S_WSTRB = '0; bus.S_BREADY = 1'b0; bus.S_ARVALID = 1'b0; bus.S_ARADDR = '0;
        bus.S_RREADY = 1'b0;

        // Reset held for 3 cycles: every output low.
        rst_n = 1'b0;
        repeat (3) tick();
        check("reset_outputs", {bus.S_AWREADY, bus.S_WREADY, bus.S_BVALID, bus.S_BRESP,
              bus.S_ARREADY, bus.S_RVALID, bus.S_RDATA, bus.S_RRESP, led_out}, 64'd0);
        rst_n = 1'b1;
        tick();
        axi_read(4'h0, rd); check("reset_ctrl", rd, 0);
        axi_read(4'h4, rd); check("reset_pat", rd, 0);
        axi_read(4'h8, rd); check("reset_period", rd, 0);

        // AW first, W three cycles later; B one cycle after the W handshake.
        bus.S_AWVALID = 1'b1; bus.S_AWADDR = 4'h4;
        check("aw_ready_idle", bus.S_AWREADY, 1);
        tick();
        bus.S_AWVALID = 1'b0;
        check("aw_held_ready", {bus.S_AWREADY, bus.S_WREADY}, 2'b01);
        tick(); tick();
        bus.S_WVALID = 1'b1; bus.S_WDATA = 32'hA5; bus.S_WSTRB = 4'hF;
        tick();
        bus.S_WVALID = 1'b0;
        check("b_not_yet", bus.S_BVALID, 0);
        tick();
        check("b_after_w", {bus.S_BVALID, bus.S_BRESP}, {1'b1, OKAY});
        bus.S_BREADY = 1'b1;
        tick();
        bus.S_BREADY = 1'b0;
        check("b_cleared", bus.S_BVALID, 0);
        axi_read(4'h4, rd); check("read_a5", rd, 32'hA5);

        foreach (vecs[i]) begin
            axi_write(vecs[i].waddr, vecs[i].wdata, vecs[i].wstrb, i % 3, (i + 1) % 3, resp);
            check($sformatf("vec%0d_bresp", i), resp, vecs[i].exp_resp);
            axi_read(vecs[i].raddr, rd);
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
        end

        // STATUS write with BREADY held low: response and backpressure held.
        bus.S_AWVALID = 1'b1; bus.S_AWADDR = 4'hC;
        bus.S_WVALID = 1'b1; bus.S_WDATA = 32'hFF; bus.S_WSTRB = 4'hF;
        tick();
        bus.S_AWVALID = 1'b0; bus.S_WVALID = 1'b0;
        tick();
        for (int k = 0; k < 5; k++) begin
            check($sformatf("b_stall%0d", k), {bus.S_BVALID, bus.S_AWREADY, bus.S_WREADY,
                  bus.S_BRESP}, {3'b100, SLVERR});
            tick();
        end
        bus.S_BREADY = 1'b1;
        tick();
        bus.S_BREADY = 1'b0;
        check("b_stall_done", bus.S_BVALID, 0);

        // Blink: PAT=0x0F, PERIOD=4, then CTRL=3 with commit edge tracked by hand.
        axi_write(4'h4, 32'h0F, 4'hF, 0, 0, resp);
        axi_write(4'h8, 32'h4, 4'hF, 0, 0, resp);
        bus.S_AWVALID = 1'b1; bus.S_AWADDR = 4'h0;
        bus.S_WVALID = 1'b1; bus.S_WDATA = 32'h3; bus.S_WSTRB = 4'hF;
        tick();
        bus.S_AWVALID = 1'b0; bus.S_WVALID = 1'b0;
        tick();
        check("blink_commit", {bus.S_BVALID, led_out}, {1'b1, 8'h00});
        bus.S_BREADY = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            tick();
            bus.S_BREADY = 1'b0;
            check($sformatf("blink_k%0d", k), led_out, (((k - 1) / 4) % 2 == 0) ? 8'h0F : 8'h00);
        end
        axi_write(4'h0, 32'h1, 4'hF, 0, 0, resp);
        for (int k = 0; k < 10; k++) begin
            tick();
            if (k % 3 == 0) check($sformatf("steady%0d", k), led_out, 8'h0F);
        end
        axi_read(4'hC, rd); check("status_steady", rd, 32'h0000_000F);

        // Read stall: RDATA and RVALID held, ARREADY low while RREADY is low.
        bus.S_ARVALID = 1'b1; bus.S_ARADDR = 4'h4;
        tick();
        bus.S_ARVALID = 1'b0;
        hs = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (bus.S_RVALID) begin
                hs = 1'b1;
                break;
            end
            tick();
        end
        if (!hs) timeout("r_stall_rvalid");
        for (int k = 0; k < 4; k++) begin
            check($sformatf("r_stall%0d", k), {bus.S_RVALID, bus.S_ARREADY, bus.S_RDATA},
                  {2'b10, 32'h0F});
            tick();
        end
        bus.S_RREADY = 1'b1;
        tick();
        bus.S_RREADY = 1'b0;
        check("r_stall_done", bus.S_RVALID, 0);

        // Reset while a read response is pending drops it.
        bus.S_ARVALID = 1'b1; bus.S_ARADDR = 4'h8;
        tick();
        bus.S_ARVALID = 1'b0;
        tick();
        check("r_pending", bus.S_RVALID, 1);
        rst_n = 1'b0;
        tick();
        check("reset_mid_read", {bus.S_RVALID, bus.S_BVALID, led_out}, 0);
        rst_n = 1'b1;
        tick();
        axi_read(4'h4, rd); check("post_reset_pat", rd, 0);

        // Random traffic against the register model.
        m_regs[0] = 0; m_regs[1] = 0; m_regs[2] = 0;
        for (int i = 0; i < 80; i++) begin
            idx = 2'($urandom_range(3, 0));
            lo  = 2'($urandom_range(3, 0));
            if ($urandom_range(1, 0) == 1) begin
                data = $urandom;
                strb = 4'($urandom_range(15, 0));
                axi_write({idx, lo}, data, strb, $urandom_range(3, 0), $urandom_range(3, 0), resp);
                check($sformatf("rnd%0d_bresp", i), resp, (idx == 2'd3) ? SLVERR : OKAY);
                if (idx != 2'd3) begin
                    m_regs[idx] = merge(m_regs[idx], data, strb);
                    if (idx == 2'd0) m_regs[0] = m_regs[0] & 32'h3;
                end
            end else begin
                if (idx == 2'd3) idx = 2'd1;
                axi_read({idx, lo}, rd);
                check($sformatf("rnd%0d_rdata", i), rd, m_regs[idx]);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
